line_raster: RTL and testbench

LINE_RASTER -- requirements
Module: line_raster

---
 rtl/line_raster.sv | 173 +++++++++++++++++
 tb/tb_line_raster.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_raster.sv
// Bresenham line rasteriser with trivial reject and per-pixel screen clipping.
// Latency: accept->SETUP->first pixel two edges later; one pixel/cycle when px_ready stays high.
// Backpressure: a stalled pixel holds its outputs; off-screen points advance without handshake.
module line_raster #(
    parameter int SCR_W   = 320,
    parameter int SCR_H   = 240,
    parameter int COLOR_W = 9
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        x0,
    input  logic [31:0]        y0,
    input  logic [31:0]        x1,
    input  logic [31:0]        y1,
    input  logic [COLOR_W-1:0] color,
    output logic               px_valid,
    input  logic               px_ready,
    output logic [8:0]         px_x,
    output logic [7:0]         px_y,
    output logic [COLOR_W-1:0] px_color,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, SETUP, STEP, FIN} state_t;

    localparam logic signed [31:0] W_S = SCR_W;
    localparam logic signed [31:0] H_S = SCR_H;

    state_t                state_q, state_d;
    logic signed [31:0]    x0_q, y0_q, x1_q, y1_q, x0_d, y0_d, x1_d, y1_d;
    logic [COLOR_W-1:0]    color_q, color_d;
    logic signed [12:0]    cx_q, cy_q, ex_q, ey_q, cx_d, cy_d, ex_d, ey_d;
    logic signed [14:0]    dx_q, dy_q, err_q, dx_d, dy_d, err_d;
    logic                  sx_neg_q, sy_neg_q, sx_neg_d, sy_neg_d;

    function automatic logic out_of_range(input logic signed [31:0] v);
        return (v < -32'sd2048) || (v > 32'sd2047);
    endfunction

    logic reject;
    assign reject = out_of_range(x0_q) || out_of_range(y0_q) ||
                    out_of_range(x1_q) || out_of_range(y1_q) ||
                    (x0_q[31] && x1_q[31]) || (y0_q[31] && y1_q[31]) ||
                    (x0_q >= W_S && x1_q >= W_S) || (y0_q >= H_S && y1_q >= H_S);

    // Coordinates are range-checked above, so 13-bit truncation is lossless here.
    logic signed [12:0] xa, ya, xb, yb;
    logic signed [13:0] diff_x, diff_y, abs_x, abs_y;
    assign xa     = x0_q[12:0];
    assign ya     = y0_q[12:0];
    assign xb     = x1_q[12:0];
    assign yb     = y1_q[12:0];
    assign diff_x = {xb[12], xb} - {xa[12], xa};
    assign diff_y = {yb[12], yb} - {ya[12], ya};
    assign abs_x  = diff_x[13] ? -diff_x : diff_x;
    assign abs_y  = diff_y[13] ? -diff_y : diff_y;

    logic signed [15:0] e2;
    logic               step_x, step_y, in_bounds, at_end, advance;
    assign e2        = {err_q, 1'b0};
    assign step_x    = e2 >= $signed({dy_q[14], dy_q});
    assign step_y    = e2 <= $signed({dx_q[14], dx_q});
    assign in_bounds = !cx_q[12] && ($unsigned(cx_q) < 13'(SCR_W)) &&
                       !cy_q[12] && ($unsigned(cy_q) < 13'(SCR_H));
    assign at_end    = (cx_q == ex_q) && (cy_q == ey_q);
    assign advance   = (state_q == STEP) && (!in_bounds || px_ready);

    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        color_d  = color_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        ex_d     = ex_q;
        ey_d     = ey_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x0_d    = x0;
                    y0_d    = y0;
                    x1_d    = x1;
                    y1_d    = y1;
                    color_d = color;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (reject) begin
                    state_d = FIN;
                end else begin
                    cx_d     = xa;
                    cy_d     = ya;
                    ex_d     = xb;
                    ey_d     = yb;
                    dx_d     = {1'b0, abs_x};
                    dy_d     = -{1'b0, abs_y};
                    err_d    = {1'b0, abs_x} - {1'b0, abs_y};
                    sx_neg_d = diff_x[13];
                    sy_neg_d = diff_y[13];
                    state_d  = STEP;
                end
            end
            STEP: begin
                if (advance) begin
                    if (at_end) begin
                        state_d = FIN;
                    end else begin
                        err_d = err_q + (step_x ? dy_q : 15'sd0) + (step_y ? dx_q : 15'sd0);
                        if (step_x) cx_d = cx_q + (sx_neg_q ? -13'sd1 : 13'sd1);
                        if (step_y) cy_d = cy_q + (sy_neg_q ? -13'sd1 : 13'sd1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            color_q  <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            ex_q     <= '0;
            ey_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            color_q  <= color_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            ex_q     <= ex_d;
            ey_q     <= ey_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == FIN);
    assign px_valid = (state_q == STEP) && in_bounds;
    assign px_x     = cx_q[8:0];
    assign px_y     = cy_q[7:0];
    assign px_color = color_q;

endmodule

// File: tb/tb_line_raster.sv
// Directed bench for line_raster: accept timing, rasterised points, clipping, reject, stall, reset abort.
module tb_line_raster;

    logic        clock = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x0, y0, x1, y1;
    logic [8:0]  color;
    logic        px_valid;
    logic        px_ready;
    logic [8:0]  px_x;
    logic [7:0]  px_y;
    logic [8:0]  px_color;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    int pix_x[$], pix_y[$], pix_e[$];
    logic [8:0] pix_c[$];
    int first_edge, done_edge, done_cnt, stall_viol;
    logic ir_after, busy_k1, timed_out;

    always #5 clock = ~clock;

    line_raster dut (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color),
        .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_y(px_y),
        .px_color(px_color), .busy(busy), .done(done)
    );

    // Edge index k counts posedges after the accept edge; values sampled at the
    // preceding negedge are the values present at edge k.
    task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input logic [8:0] col, input bit stall_mode);
        int k, vcnt, n;
        logic prev_stall;
        logic [8:0] hx, hc;
        logic [7:0] hy;
        pix_x.delete(); pix_y.delete(); pix_e.delete(); pix_c.delete();
        first_edge = -1; done_edge = -1; done_cnt = 0; stall_viol = 0;
        ir_after = 1'b0; busy_k1 = 1'b0; timed_out = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1; color = col; in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        x0 = 32'hDEAD; y0 = 32'hBEEF; color = 9'h0;
        k = 0; vcnt = 0; prev_stall = 1'b0; hx = '0; hy = '0; hc = '0;
        while (k < 3000) begin
            @(negedge clock);
            k++;
            if (k == 1) busy_k1 = busy;
            if (prev_stall && (!px_valid || px_x !== hx || px_y !== hy || px_color !== hc))
                stall_viol++;
            if (done) begin
                done_cnt++;
                if (done_edge < 0) done_edge = k;
            end
            if (done_edge >= 0 && k == done_edge + 1) begin
                ir_after = in_ready;
                break;
            end
            if (px_valid) begin
                if (first_edge < 0) first_edge = k;
                px_ready = stall_mode ? (vcnt % 3 == 0) : 1'b1;
                vcnt++;
                if (px_ready) begin
                    pix_x.push_back(int'(px_x));
                    pix_y.push_back(int'(px_y));
                    pix_c.push_back(px_color);
                    pix_e.push_back(k);
                end
                prev_stall = !px_ready;
                hx = px_x; hy = px_y; hc = px_color;
            end else begin
                px_ready = 1'b1;
                prev_stall = 1'b0;
            end
        end
        if (k >= 3000) timed_out = 1'b1;
        px_ready = 1'b1;
    endtask

    task automatic test_reset;
        resetn = 1'b0; in_valid = 1'b0; px_ready = 1'b1;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = '0;
        #12;
        checks++;
        if (in_ready !== 1'b1 || px_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 ||
            px_x !== 9'd0 || px_y !== 8'd0 || px_color !== 9'd0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b done=%b busy=%b x=%0d y=%0d c=%0d, required 1 0 0 0 0 0 0",
                     in_ready, px_valid, done, busy, px_x, px_y, px_color);
        end
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_horizontal;
        run_line(10, 20, 14, 20, 9'h1A5, 1'b0);
        checks++;
        if (timed_out !== 1'b0 || pix_x.size() != 5) begin
            errors++;
            $display("FAIL horiz_count: got %0d pixels (timeout=%b), required 5", pix_x.size(), timed_out);
        end
        checks++;
        if (busy_k1 !== 1'b1) begin
            errors++;
            $display("FAIL horiz_busy: got %b, required 1", busy_k1);
        end
        for (int i = 0; i < pix_x.size(); i++) begin
            checks++;
            if (pix_x[i] != 10 + i || pix_y[i] != 20 || pix_c[i] !== 9'h1A5 || pix_e[i] != 2 + i) begin
                errors++;
                $display("FAIL horiz_pix%0d: got (%0d,%0d) c=%h edge %0d, required (%0d,20) c=1a5 edge %0d",
                         i, pix_x[i], pix_y[i], pix_c[i], pix_e[i], 10 + i, 2 + i);
            end
        end
        checks++;
        if (done_edge != 7 || done_cnt != 1 || ir_after !== 1'b1) begin
            errors++;
            $display("FAIL horiz_done: edge %0d count %0d ready %b, required edge 7 count 1 ready 1",
                     done_edge, done_cnt, ir_after);
        end
    endtask

    task automatic test_steep;
        int ex[7] = '{3, 3, 4, 4, 4, 5, 5};
        int ey[7] = '{3, 4, 5, 6, 7, 8, 9};
        run_line(3, 3, 5, 9, 9'h055, 1'b0);
        checks++;
        if (pix_x.size() != 7) begin
            errors++;
            $display("FAIL steep_count: got %0d, required 7", pix_x.size());
        end
        for (int i = 0; i < pix_x.size() && i < 7; i++) begin
            checks++;
            if (pix_x[i] != ex[i] || pix_y[i] != ey[i]) begin
                errors++;
                $display("FAIL steep_pix%0d: got (%0d,%0d), required (%0d,%0d)", i, pix_x[i], pix_y[i], ex[i], ey[i]);
            end
        end
        run_line(5, 9, 3, 3, 9'h055, 1'b0);
        checks++;
        if (pix_x.size() != 7 || pix_x[0] != 5 || pix_y[0] != 9 || pix_x[pix_x.size()-1] != 3 ||
            pix_y[pix_y.size()-1] != 3) begin
            errors++;
            $display("FAIL steep_reverse: got %0d pixels, required 7 from (5,9) to (3,3)", pix_x.size());
        end
    endtask

    task automatic test_clip;
        run_line(-5, 5, 5, 5, 9'h0F0, 1'b0);
        checks++;
        if (pix_x.size() != 6 || first_edge != 7) begin
            errors++;
            $display("FAIL clip_count: got %0d pixels first edge %0d, required 6 at edge 7", pix_x.size(), first_edge);
        end
        for (int i = 0; i < pix_x.size(); i++) begin
            checks++;
            if (pix_x[i] != i || pix_y[i] != 5) begin
                errors++;
                $display("FAIL clip_pix%0d: got (%0d,%0d), required (%0d,5)", i, pix_x[i], pix_y[i], i);
            end
        end
        checks++;
        if (done_edge != 13 || done_cnt != 1) begin
            errors++;
            $display("FAIL clip_done: edge %0d count %0d, required edge 13 count 1", done_edge, done_cnt);
        end
        run_line(319, 239, 321, 241, 9'h1FF, 1'b0);
        checks++;
        if (pix_x.size() != 1 || pix_x[0] != 319 || pix_y[0] != 239 || done_edge != 5) begin
            errors++;
            $display("FAIL corner: got %0d pixels done edge %0d, required 1 pixel (319,239) done edge 5",
                     pix_x.size(), done_edge);
        end
    endtask

    task automatic test_reject;
        int ax0[2] = '{400, 5000};
        int ay0[2] = '{10, 10};
        int ax1[2] = '{500, 20};
        int ay1[2] = '{50, 30};
        for (int t = 0; t < 2; t++) begin
            run_line(ax0[t], ay0[t], ax1[t], ay1[t], 9'h111, 1'b0);
            checks++;
            if (first_edge != -1 || done_edge != 2 || done_cnt != 1 || ir_after !== 1'b1) begin
                errors++;
                $display("FAIL reject%0d: first px edge %0d done edge %0d count %0d ready %b, required none 2 1 1",
                         t, first_edge, done_edge, done_cnt, ir_after);
            end
        end
    endtask

    task automatic test_zero_len;
        run_line(7, 7, 7, 7, 9'h0AA, 1'b0);
        checks++;
        if (pix_x.size() != 1 || pix_x[0] != 7 || pix_y[0] != 7 || done_edge != 3) begin
            errors++;
            $display("FAIL zero_len: got %0d pixels done edge %0d, required 1 pixel (7,7) done edge 3",
                     pix_x.size(), done_edge);
        end
    endtask

    task automatic test_stall;
        run_line(0, 0, 3, 0, 9'h123, 1'b1);
        checks++;
        if (pix_x.size() != 4 || stall_viol != 0) begin
            errors++;
            $display("FAIL stall_count: got %0d pixels %0d unstable stalls, required 4 and 0", pix_x.size(), stall_viol);
        end
        for (int i = 0; i < pix_x.size(); i++) begin
            checks++;
            if (pix_x[i] != i || pix_y[i] != 0 || pix_c[i] !== 9'h123) begin
                errors++;
                $display("FAIL stall_pix%0d: got (%0d,%0d) c=%h, required (%0d,0) c=123", i, pix_x[i], pix_y[i], pix_c[i], i);
            end
        end
        checks++;
        if (done_edge != 12 || done_cnt != 1) begin
            errors++;
            $display("FAIL stall_done: edge %0d count %0d, required edge 12 count 1", done_edge, done_cnt);
        end
    endtask

    task automatic test_reset_midline;
        int bad;
        @(negedge clock);
        x0 = 0; y0 = 100; x1 = 300; y1 = 100; color = 9'h077; in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(negedge clock);
        px_ready = 1'b1;
        @(negedge clock);
        px_ready = 1'b1;
        @(negedge clock);
        px_ready = 1'b0;
        @(negedge clock);
        checks++;
        if (px_valid !== 1'b1 || px_x !== 9'd1) begin
            errors++;
            $display("FAIL midline_stall: vld=%b x=%0d, required 1 and 1", px_valid, px_x);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (px_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1 || px_x !== 9'd0) begin
            errors++;
            $display("FAIL midline_abort: vld=%b busy=%b done=%b rdy=%b x=%0d, required 0 0 0 1 0",
                     px_valid, busy, done, in_ready, px_x);
        end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (done !== 1'b0 || px_valid !== 1'b0) bad++;
        end
        resetn = 1'b1;
        px_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1 if (done !== 1'b0 || px_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midline_quiet: %0d samples with done/px_valid set, required 0", bad);
        end
        run_line(0, 1, 2, 1, 9'h0C3, 1'b0);
        checks++;
        if (busy_k1 !== 1'b1 || pix_x.size() != 3 || pix_e.size() != 3 || pix_e[0] != 2) begin
            errors++;
            $display("FAIL post_reset_accept: busy %b pixels %0d, required busy 1 and 3 pixels from edge 2",
                     busy_k1, pix_x.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_horizontal();
        test_steep();
        test_clip();
        test_reject();
        test_zero_len();
        test_stall();
        test_reset_midline();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
